// File: rtl/pwla_pkg.sv
// rtl/pwla_pkg.sv - Q6.10 constants and types shared by the pwla activation blocks
package pwla_pkg;

  localparam int FRAC  = 10;
  localparam int ONE   = 1 << FRAC;
  localparam int D_MAX = ONE / 4;
  // f*(1-f) peaks at 0.25 = D_MAX, which needs FRAC-1 bits unsigned
  localparam int D_W   = FRAC - 1;

  typedef logic signed [15:0] q6_10_t;

endpackage

// File: rtl/pwla_mul_q10.sv
// rtl/pwla_mul_q10.sv - combinational signed Q6.10 x unsigned derivative multiply with floor shift
module pwla_mul_q10 #(
  parameter int FRAC = pwla_pkg::FRAC,
  parameter int D_W  = pwla_pkg::D_W
) (
  input  pwla_pkg::q6_10_t grad,
  input  logic [D_W-1:0]   d,
  output pwla_pkg::q6_10_t g_x
);

  localparam int P_W = 16 + D_W;

  logic signed [P_W-1:0] prod;

  // zero-extend d so the multiply stays signed; |result| <= 8192 so the truncation never wraps
  assign prod = grad * $signed({1'b0, d});
  assign g_x  = 16'(prod >>> FRAC);

endmodule

// File: rtl/pwla_sigmoid_grad.sv
// rtl/pwla_sigmoid_grad.sv - two-stage valid/ready pipeline computing grad * f * (1 - f)
module pwla_sigmoid_grad #(
  parameter int FRAC = pwla_pkg::FRAC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] f_x,
  input  logic [15:0] grad,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] g_x,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int ONE = 1 << FRAC;
  localparam int D_W = FRAC - 1;
  localparam int P_W = 2 * FRAC + 2;

  logic                   s1_valid;
  logic [D_W-1:0]         s1_d;
  pwla_pkg::q6_10_t       s1_grad;
  logic                   s2_valid;
  pwla_pkg::q6_10_t       s2_gx;

  logic                   s1_adv;
  logic                   s2_adv;
  logic [FRAC:0]          fc;
  logic [FRAC:0]          one_minus;
  logic [P_W-1:0]         d_prod;
  logic [D_W-1:0]         d_next;
  pwla_pkg::q6_10_t       gx_next;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign g_x       = s2_gx;

  // sigmoid outputs above 1.0 are treated as saturated, giving a zero derivative
  assign fc        = (f_x > 16'(ONE)) ? (FRAC+1)'(ONE) : f_x[FRAC:0];
  assign one_minus = (FRAC+1)'(ONE) - fc;
  assign d_prod    = P_W'(fc) * P_W'(one_minus);
  assign d_next    = D_W'(d_prod >> FRAC);

  pwla_mul_q10 #(.FRAC(FRAC), .D_W(D_W)) u_mul (
    .grad (s1_grad),
    .d    (s1_d),
    .g_x  (gx_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_grad  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_d    <= d_next;
        s1_grad <= grad;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_gx    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_gx <= gx_next;
      end
    end
  end

endmodule

// File: tb/tb_pwla_sigmoid_grad.sv
// tb/tb_pwla_sigmoid_grad.sv - randomized and directed checks of pwla_sigmoid_grad against an arithmetic model
module tb_pwla_sigmoid_grad;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] f_x;
  logic [15:0] grad;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] g_x;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q[$];
  int acc_q[$];
  bit lat_mode = 1'b0;
  bit stall_prev = 1'b0;
  int held_gx = 0;

  always #5 clk = ~clk;

  pwla_sigmoid_grad dut (
    .clk       (clk),
    .rst       (rst),
    .f_x       (f_x),
    .grad      (grad),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g_x       (g_x),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_grad(input logic [15:0] fx, input logic [15:0] gr);
    int fc, d, g, p;
    fc = (int'(fx) > 1024) ? 1024 : int'(fx);
    d  = (fc * (1024 - fc)) / 1024;
    g  = int'(shortint'(gr));
    p  = g * d;
    return (p >= 0) ? p / 1024 : -((-p + 1023) / 1024);
  endfunction

  // one clock: drive, evaluate handshakes mid-cycle against the model, advance
  task automatic step(input logic v, input logic [15:0] fx, input logic [15:0] gr, input logic rdy);
    int e, a;
    in_valid = v; f_x = fx; grad = gr; out_ready = rdy;
    @(negedge clk);
    cyc++;
    if (stall_prev) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_gx", int'($signed(g_x)), held_gx);
    end
    check("in_ready", int'(in_ready), int'((exp_q.size() < 2) || rdy));
    if (exp_q.size() == 0) check("idle_out_valid", int'(out_valid), 0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("g_x", int'($signed(g_x)), e);
        if (lat_mode) check("latency", cyc - a, 2);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_grad(fx, gr));
      acc_q.push_back(cyc);
    end
    stall_prev = out_valid && !out_ready;
    held_gx = int'($signed(g_x));
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [15:0] fx, input logic [15:0] gr);
    step(1'b1, fx, gr, 1'b1);
    repeat (3) step(1'b0, 16'd0, 16'd0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; f_x = '0; grad = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_g_x", int'(g_x), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    lat_mode = 1'b1;
    single(16'd512, 16'd1024);
    single(16'd256, 16'd2048);
    single(16'd256, 16'hFFFF);
    single(16'd0, 16'd32767);
    single(16'd1024, 16'd32767);
    single(16'd2000, 16'd32767);
    single(16'd512, 16'h8000);

    for (int i = 0; i < 8; i++) step(1'b1, 16'(100 * i + 37), 16'(i * 4000 - 15000), 1'b1);
    repeat (3) step(1'b0, 16'd0, 16'd0, 1'b1);
    lat_mode = 1'b0;

    for (int i = 0; i < 5; i++) step(1'b1, 16'(300 + i), 16'(1000 * i - 3000), 1'b0);
    check("stall_inflight", exp_q.size(), 2);
    repeat (4) step(1'b0, 16'd0, 16'd0, 1'b1);
    check("stall_drained", exp_q.size(), 0);

    step(1'b1, 16'd512, 16'd1024, 1'b0);
    step(1'b1, 16'd256, 16'd2048, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", int'(out_valid), 0);
    exp_q.delete();
    acc_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_g_x", int'(g_x), 0);
    check("post_rst_in_ready", int'(in_ready), 1);
    repeat (5) step(1'b0, 16'd0, 16'd0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] fx;
      fx = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1100));
      step(1'($urandom_range(0, 3) != 0), fx, 16'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1'b0, 16'd0, 16'd0, 1'b1);
    check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pwla_sigmoid_grad.md
PWLA_SIGMOID_GRAD -- requirements
Module: pwla_sigmoid_grad

Interface
REQ-001 SHALL have parameter FRAC, default 10: fractional bits of Q6.10 fixed point (1.0 = 1024).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port f_x  input  16  unsigned Q6.10 sigmoid output from forward pass.
REQ-005 SHALL have port grad  input  16  signed Q6.10 upstream gradient.
REQ-006 SHALL have port in_valid  input  1  f_x/grad valid.
REQ-007 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have port g_x  output  16  signed Q6.10 result grad*f*(1-f).
REQ-009 SHALL have port out_valid  output  1  g_x valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts g_x this cycle.

Function
REQ-011 SHALL accept an input transfer exactly on a rising edge where in_valid=1 and in_ready=1.
REQ-012 SHALL emit an output transfer exactly on a rising edge where out_valid=1 and out_ready=1.
REQ-013 SHALL clamp f_x to 1024 when f_x > 1024 before any arithmetic.
REQ-014 SHALL compute in stage 1 d = (fc * (1024 - fc)) >> FRAC, unsigned; d in [0,256], held in 9 bits; fc = clamped f_x.
REQ-015 SHALL compute in stage 2 g_x = (grad * d) >>> FRAC, signed 25-bit product, arithmetic shift (round toward negative infinity).
REQ-016 SHALL not saturate: result range is [-8192, 8192] and always fits 16 bits signed.
REQ-017 SHALL be a 2-stage pipeline with per-stage valid bits s1_valid, s2_valid; out_valid = s2_valid.
REQ-018 SHALL advance stage 2 when s2_valid=0 or out_ready=1; stage 2 loads stage-1 contents, s2_valid <= s1_valid.
REQ-019 SHALL advance stage 1 when s1_valid=0 or stage 2 advances; in_ready equals this stage-1 advance condition.
REQ-020 SHALL have latency 2 cycles from input acceptance to out_valid with out_ready held 1, and sustain one transfer per cycle.
REQ-021 SHALL hold g_x and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, with out_ready=0 and both stages full, deassert in_ready and drop no data; at most 2 transactions in flight.
REQ-023 SHALL preserve transaction order; simultaneous input accept and output emit in one cycle are both honoured.
REQ-024 SHALL make in_ready depend combinationally on out_ready only; no combinational path from in_valid to out_valid.

Reset
REQ-025 SHALL, on rst=1 at any time, asynchronously clear s1_valid, s2_valid; out_valid=0, g_x=0, in_ready=1 after reset release.
REQ-026 SHALL discard in-flight transactions when reset asserts mid-operation; no output for them after release.
REQ-027 SHALL reset datapath registers to 0 as well as valid bits.

Structure
REQ-028 SHALL take Q6.10 constants (FRAC=10, ONE=1024, D_MAX=256) and the q6_10_t 16-bit signed typedef from shared package pwla_pkg, also used by pwla_sigmoid.
REQ-029 SHALL place the stage-2 signed multiply-and-shift in sub-module pwla_mul_q10 (16b signed x 9b unsigned -> 16b signed), combinational.
REQ-030 SHALL contain no other sub-modules; pipeline control stays in pwla_sigmoid_grad.

Verification
REQ-031 SHALL cover f_x=512, grad=1024, out_ready=1 -> g_x=256 exactly 2 cycles after acceptance.
REQ-032 SHALL cover f_x=256, grad=2048 -> d=192, g_x=384; f_x=256, grad=-1 -> g_x=-1 (floor rounding).
REQ-033 SHALL cover f_x=0, 1024, 2000 with grad=32767 -> g_x=0 each; f_x=512, grad=-32768 -> g_x=-8192.
REQ-034 SHALL cover back-to-back 8 inputs with out_ready=1 -> 8 outputs on consecutive cycles in order.
REQ-035 SHALL cover out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 after 2 accepts, g_x stable, no loss on release.
REQ-036 SHALL cover rst asserted with 2 transactions in flight -> out_valid=0 immediately, no stale output after release.
